// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if
//   Requester-side bundle of the SRAM arbiter. All three requesters share it;
//   per-requester fields are packed vectors (requester i owns bit i of
//   req/we/ack, and slice [i*W +: W] of addr/wdata).
//
//   req    requester -> arbiter  level request, one bit per requester
//   we     requester -> arbiter  1 = write, 0 = read
//   addr   requester -> arbiter  3 packed word addresses
//   wdata  requester -> arbiter  3 packed write data words
//   ack    arbiter -> requester  one-cycle completion pulse (one-hot or zero)
//   rdata  arbiter -> requester  read data, valid in the ack cycle, then held
//   busy   arbiter -> requester  arbiter is not idle
//
//   master: the requester side.  slave: the arbiter.
// ---------------------------------------------------------------------------
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) ();
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          ack;
  logic [DATA_W-1:0]   rdata;
  logic                busy;

  modport master (output req, we, addr, wdata, input ack, rdata, busy);
  modport slave  (input req, we, addr, wdata, output ack, rdata, busy);
endinterface

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//   Shares one asynchronous 16-bit SRAM between three requesters (0: bulk
//   loader, 1: trail/sprite writer, 2: debug/host port) with round-robin
//   arbitration. Each access is a fixed sequence:
//     IDLE -> ACCESS (ACCESS_CYCLES cycles) -> DONE (1 cycle, ack) -> IDLE
//   All SRAM pins are driven straight from flops.
//
//   Ports
//     clk, reset_n   clock, asynchronous active-low reset
//     bus            sram_arbiter_if.slave requester bundle
//     sram_addr      SRAM word address
//     sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  active-low controls
//     sram_dq_out    data towards the pad, sram_dq_oe pad drive enable
//     sram_dq_in     data from the pad
//
//   Optional feature: define SRAM_ARB_BURST_EN to let the current grantee
//   chain up to BURST_MAX accesses, going DONE -> ACCESS directly while its
//   req stays high. Without the macro every access passes through IDLE.
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,   // 1..15
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16
`ifdef SRAM_ARB_BURST_EN
  , parameter int BURST_MAX   = 8
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  sram_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n,
  output logic [DATA_W-1:0]  sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [DATA_W-1:0]  sram_dq_in
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  gnt_idx;    // requester owning the current access
  logic [1:0]  last_ptr;   // last granted requester, rotation starts after it
  logic        cur_we;

`ifdef SRAM_ARB_BURST_EN
  localparam int BW = $clog2(BURST_MAX + 1);
  logic [BW-1:0] burst_cnt;  // accesses done in the current burst
`endif

  // ---------------------------------------------------------------------
  // Round-robin pick: scan the two requesters after last_ptr in cyclic
  // order, then last_ptr itself.
  // ---------------------------------------------------------------------
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  logic [1:0]        c0, c1, pick_idx, start_idx;
  logic              pick_valid, start_fresh, start_burst, start;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    c0         = next_idx(last_ptr);
    c1         = next_idx(c0);
    pick_valid = |bus.req;
    if (bus.req[c0])      pick_idx = c0;
    else if (bus.req[c1]) pick_idx = c1;
    else                  pick_idx = last_ptr;

    start_fresh = (state == IDLE) && pick_valid;
`ifdef SRAM_ARB_BURST_EN
    start_burst = (state == DONE) && bus.req[gnt_idx] &&
                  (int'(burst_cnt) < BURST_MAX);
`else
    start_burst = 1'b0;
`endif
    start     = start_fresh || start_burst;
    start_idx = start_burst ? gnt_idx : pick_idx;

    cap_we    = bus.we[0];
    cap_addr  = bus.addr[0 +: ADDR_W];
    cap_wdata = bus.wdata[0 +: DATA_W];
    case (start_idx)
      2'd1: begin
        cap_we    = bus.we[1];
        cap_addr  = bus.addr[ADDR_W +: ADDR_W];
        cap_wdata = bus.wdata[DATA_W +: DATA_W];
      end
      2'd2: begin
        cap_we    = bus.we[2];
        cap_addr  = bus.addr[2*ADDR_W +: ADDR_W];
        cap_wdata = bus.wdata[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Sequencer. Outputs are registered so the SRAM pins never glitch; the
  // values loaded on an edge are the ones the pins show in the next state.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      gnt_idx     <= 2'd0;
      last_ptr    <= 2'd2;     // requester 0 wins the first arbitration
      cur_we      <= 1'b0;
      sram_addr   <= '0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      bus.ack     <= '0;
      bus.rdata   <= '0;
      bus.busy    <= 1'b0;
`ifdef SRAM_ARB_BURST_EN
      burst_cnt   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments only; the later bus.ack[gnt_idx]
      // update overrides this default, which makes ack a one-cycle pulse.
      bus.ack <= '0;

      if (start) begin
        // Capture the grantee's request; its inputs are ignored afterwards.
        state       <= ACCESS;
        cnt         <= '0;
        gnt_idx     <= start_idx;
        last_ptr    <= start_idx;
        cur_we      <= cap_we;
        sram_addr   <= cap_addr;
        sram_dq_out <= cap_wdata;
        sram_ce_n   <= 1'b0;
        sram_ub_n   <= 1'b0;
        sram_lb_n   <= 1'b0;
        sram_oe_n   <= cap_we;
        sram_we_n   <= !cap_we;
        sram_dq_oe  <= cap_we;
        bus.busy    <= 1'b1;
`ifdef SRAM_ARB_BURST_EN
        burst_cnt   <= start_burst ? burst_cnt + 1'b1 : BW'(1);
`endif
      end else begin
        case (state)
          IDLE: ;
          ACCESS: begin
            if (cnt == CNT_LAST) begin
              // Final strobe edge: read data is sampled while OE_N is
              // still low, then both strobes release. CE_N, the address
              // and the write drive stay on through DONE for hold time.
              state            <= DONE;
              bus.ack[gnt_idx] <= 1'b1;
              sram_oe_n        <= 1'b1;
              sram_we_n        <= 1'b1;
              if (!cur_we) bus.rdata <= sram_dq_in;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          DONE: begin
            state      <= IDLE;
            sram_ce_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            bus.busy   <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//   Self-checking bench for sram_arbiter. A behavioural SRAM answers reads
//   and stores writes from the pins. Directed sequences cover reset, single
//   read/write, rotation (or burst when SRAM_ARB_BURST_EN is defined) and
//   reset during a write; random rounds then compare grant order, ack
//   spacing and data against a queue-based reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int AC = 2;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int ROUNDS = 20;
`ifdef SRAM_ARB_BURST_EN
  localparam int BM = 4;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] sram_addr;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [DW-1:0] sram_dq_out;
  logic          sram_dq_oe;
  logic [DW-1:0] sram_dq_in = '0;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(
    .ACCESS_CYCLES(AC), .ADDR_W(AW), .DATA_W(DW)
`ifdef SRAM_ARB_BURST_EN
    , .BURST_MAX(BM)
`endif
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .sram_addr  (sram_addr),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- SRAM model and reference memory ----------------
  logic [DW-1:0] sram_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem  [logic [AW-1:0]];

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hC3A5 ^ {a[19:16], 12'h000};
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] = sram_dq_out;
    if (!sram_ce_n && !sram_oe_n)
      sram_dq_in = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : init_word(sram_addr);
    else
      sram_dq_in = 16'hEEEE;
    if (reset_n) check("ack_onehot", 32'($onehot0(bus.ack)), 1);
  end

  // ---------------- requester helpers ----------------
  task automatic drive(input int i, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i] = r;
    bus.we[i]  = w;
    bus.addr[i*AW +: AW]  = a;
    bus.wdata[i*DW +: DW] = d;
  endtask

  function automatic int ack_idx(input logic [2:0] a);
    case (a)
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 0;
    endcase
  endfunction

  // One isolated access; pin activity is measured per cycle after the grant.
  task automatic single(input int idx, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    int ack_at, ack_n, oe_lo, we_lo, dq_hi, bad_addr;
    logic [2:0] ack_bits;
    ack_at = 0; ack_n = 0; oe_lo = 0; we_lo = 0; dq_hi = 0; bad_addr = 0; ack_bits = '0;
    drive(idx, 1'b1, w, a, d);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (!sram_oe_n) oe_lo++;
      if (!sram_we_n) we_lo++;
      if (sram_dq_oe) dq_hi++;
      if (!sram_ce_n && sram_addr !== a) bad_addr++;
      if (bus.ack != 3'b000) begin
        ack_n++;
        if (ack_at == 0) begin ack_at = n; ack_bits = bus.ack; end
        bus.req[idx] = 1'b0;
      end
    end
    check($sformatf("single%0d_latency", idx), ack_at, AC + 1);
    check($sformatf("single%0d_ack_count", idx), ack_n, 1);
    check($sformatf("single%0d_ack_who", idx), ack_bits, 32'(1 << idx));
    check($sformatf("single%0d_addr", idx), bad_addr, 0);
    check($sformatf("single%0d_oe_low", idx), oe_lo, w ? 0 : AC);
    check($sformatf("single%0d_we_low", idx), we_lo, w ? AC : 0);
    check($sformatf("single%0d_dq_oe_high", idx), dq_hi, w ? AC + 1 : 0);
    if (w) check($sformatf("single%0d_mem", idx), sram_mem.exists(a) ? sram_mem[a] : 16'h0, d);
    else   check($sformatf("single%0d_rdata", idx), bus.rdata, exp_rd);
  endtask

  // ---------------- reference model for random rounds ----------------
  typedef struct packed { logic w; logic [AW-1:0] a; logic [DW-1:0] d; } op_t;
  typedef struct packed { logic [1:0] idx; logic cont; } exp_t;

  op_t           q [3][$];
  exp_t          ex [$];
  logic [AW-1:0] pool [8];
  int            model_last;

  task automatic rand_round();
    int rem[3];
    int total, last, g, k, n, prev, limit, who, burst, gap;
    op_t op;
    exp_t e;
    total = 0;
    for (int i = 0; i < 3; i++) begin
      rem[i] = $urandom_range(0, 5);
      total += rem[i];
      for (int j = 0; j < rem[i]; j++) begin
        op.w = 1'($urandom_range(0, 1));
        op.a = pool[$urandom_range(0, 7)];
        op.d = DW'($urandom);
        q[i].push_back(op);
      end
    end
    // Expected service order: rotate from the last grant over requesters
    // that still have work; in burst builds the grantee keeps the bus while
    // it has work, up to BM accesses.
    ex.delete();
    last = model_last;
    while (total > 0) begin
      g = -1;
      for (int s = 1; s <= 3; s++)
        if (g < 0 && rem[(last + s) % 3] > 0) g = (last + s) % 3;
      last = g;
      e.idx = 2'(g); e.cont = 1'b0;
      ex.push_back(e);
      rem[g]--; total--;
`ifdef SRAM_ARB_BURST_EN
      burst = 1;
      while (rem[g] > 0 && burst < BM) begin
        e.cont = 1'b1;
        ex.push_back(e);
        rem[g]--; total--; burst++;
      end
`else
      burst = 0;
`endif
    end
    model_last = last;

    for (int i = 0; i < 3; i++)
      if (q[i].size() > 0) drive(i, 1'b1, q[i][0].w, q[i][0].a, q[i][0].d);
      else bus.req[i] = 1'b0;

    k = 0; n = 0; prev = 0;
    limit = ex.size() * (AC + 2) + 10;
    while (k < ex.size() && n < limit) begin
      @(negedge clk);
      n++;
      if (bus.ack != 3'b000) begin
        e = ex[k];
        who = ack_idx(bus.ack);
        check("rnd_who", bus.ack, 32'(1 << e.idx));
        gap = (k == 0 || e.cont) ? AC + 1 : AC + 2;
        check("rnd_gap", n - prev, gap);
        prev = n;
        if (q[who].size() > 0) begin
          op = q[who].pop_front();
          if (op.w) begin
            ref_mem[op.a] = op.d;
            check("rnd_wr", sram_mem.exists(op.a) ? sram_mem[op.a] : 16'h0, op.d);
          end else begin
            check("rnd_rd", bus.rdata, ref_read(op.a));
          end
        end
        if (q[who].size() > 0) drive(who, 1'b1, q[who][0].w, q[who][0].a, q[who][0].d);
        else bus.req[who] = 1'b0;
        k++;
      end
    end
    check("rnd_all_acked", k, ex.size());
    bus.req = '0;
    for (int i = 0; i < 3; i++) q[i].delete();
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int order[$];
    int at[$];
    int n;
    logic [AW-1:0] ba;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_ctl_n", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
    check("rst_addr", sram_addr, 0);
    check("rst_dq", {sram_dq_oe, sram_dq_out}, 0);
    check("rst_rdata", bus.rdata, 0);
    reset_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("idle_quiet", {bus.busy, bus.ack, sram_ce_n, sram_oe_n, sram_we_n,
                           sram_ub_n, sram_lb_n, sram_dq_oe}, {1'b0, 3'b000, 5'b11111, 1'b0});
    end

`ifndef SRAM_ARB_BURST_EN
    // All three held: strict rotation starting at requester 0.
    drive(0, 1'b1, 1'b0, 20'h00100, 16'h0);
    drive(1, 1'b1, 1'b0, 20'h00200, 16'h0);
    drive(2, 1'b1, 1'b0, 20'h00300, 16'h0);
    for (n = 1; n <= 60 && order.size() < 6; n++) begin
      @(negedge clk);
      if (bus.ack != 3'b000) begin
        order.push_back(ack_idx(bus.ack));
        at.push_back(n);
        if (order.size() == 6) bus.req = '0;
      end
    end
    check("rr_count", order.size(), 6);
    for (int i = 0; i < order.size(); i++) begin
      check("rr_order", order[i], i % 3);
      if (i > 0) check("rr_spacing", at[i] - at[i-1], AC + 2);
    end
`else
    // Requester 0 streams writes while 1 waits: BM acks to 0, then 1.
    ba = 20'h00500;
    drive(0, 1'b1, 1'b1, ba, ~ba[15:0]);
    drive(1, 1'b1, 1'b0, 20'h00600, 16'h0);
    for (n = 1; n <= 80 && order.size() < 6; n++) begin
      @(negedge clk);
      if (bus.ack != 3'b000) begin
        order.push_back(ack_idx(bus.ack));
        at.push_back(n);
        if (bus.ack[0]) begin
          ba = ba + 20'd1;
          drive(0, 1'b1, 1'b1, ba, ~ba[15:0]);
        end
        if (bus.ack[1]) bus.req[1] = 1'b0;
        if (order.size() == 6) bus.req = '0;
      end
    end
    check("burst_count", order.size(), 6);
    for (int i = 0; i < order.size(); i++) begin
      check("burst_order", order[i], (i == 4) ? 1 : 0);
      if (i > 0) check("burst_spacing", at[i] - at[i-1], (i < BM) ? AC + 1 : AC + 2);
    end
    for (int i = 0; i < BM; i++) begin
      ba = 20'h00500 + 20'(i);
      check("burst_mem", sram_mem.exists(ba) ? sram_mem[ba] : 16'h0, ~ba[15:0]);
    end
`endif
    repeat (3) @(negedge clk);

    sram_mem[20'h4B000] = 16'hABCD;
    ref_mem[20'h4B000]  = 16'hABCD;
    single(0, 1'b0, 20'h4B000, 16'h0000, 16'hABCD);
    repeat (2) @(negedge clk);
    single(1, 1'b1, 20'h00010, 16'h1234, 16'h0000);
    ref_mem[20'h00010] = 16'h1234;
    repeat (2) @(negedge clk);

    // Reset in the middle of a write: pins release at once, no ack.
    drive(1, 1'b1, 1'b1, 20'h00777, 16'h5555);
    @(negedge clk);
    check("pre_rst_we_n", sram_we_n, 0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_we_n", sram_we_n, 1);
    check("rst_mid_dq_oe", sram_dq_oe, 0);
    check("rst_mid_ce_n", sram_ce_n, 1);
    check("rst_mid_busy", bus.busy, 0);
    bus.req = '0;
    repeat (3) begin @(negedge clk); check("rst_no_ack", bus.ack, 0); end
    reset_n = 1'b1;
    repeat (3) begin @(negedge clk); check("post_rst_no_ack", bus.ack, 0); end
    drive(0, 1'b1, 1'b0, 20'h4B000, 16'h0);
    drive(1, 1'b1, 1'b0, 20'h00010, 16'h0);
    order.delete();
    for (n = 1; n <= 30 && order.size() < 2; n++) begin
      @(negedge clk);
      if (bus.ack != 3'b000) begin
        order.push_back(ack_idx(bus.ack));
        bus.req = bus.req & ~bus.ack;
      end
    end
    check("post_rst_acks", order.size(), 2);
    if (order.size() == 2) begin
      check("post_rst_first", order[0], 0);
      check("post_rst_second", order[1], 1);
    end
    bus.req = '0;
    model_last = 1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) pool[i] = {4'hA, 16'($urandom)};
    for (int r = 0; r < ROUNDS; r++) rand_round();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
